// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I encoding constants for the instruction encoder.
// Contents:
//   op_sel_e       request operation select (LH, SH, ANDI, BEQ, ADD, SUB, AND, OR)
//   OPC_* / F3_* / F7_*  opcode, funct3 and funct7 field values
//   IMM12_* / IMMB_*     legal immediate ranges for I/S and B formats
//   imm12_fits / immb_fits  range-check helpers
package instruction_encoder_pkg;

    typedef enum logic [2:0] {
        OP_LH   = 3'd0,
        OP_SH   = 3'd1,
        OP_ANDI = 3'd2,
        OP_BEQ  = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_AND  = 3'd6,
        OP_OR   = 3'd7
    } op_sel_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_SH      = 3'b001;
    localparam logic [2:0] F3_ANDI    = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;

    function automatic logic imm12_fits(input logic [31:0] imm);
        return ($signed(imm) >= IMM12_MIN) && ($signed(imm) <= IMM12_MAX);
    endfunction

    // Branch offsets are in bytes but the LSB is not encoded, so it must be 0.
    function automatic logic immb_fits(input logic [31:0] imm);
        return ($signed(imm) >= IMMB_MIN) && ($signed(imm) <= IMMB_MAX) && !imm[0];
    endfunction

endpackage

// File: rtl/instruction_encoder_field_packer.sv
// Combinational packer: operation select plus register/immediate fields
// into one RV32I instruction word, with an immediate range verdict.
// Ports:
//   op        in   operation select
//   rd        in   destination register (unused for SH/BEQ)
//   rs1       in   source register 1
//   rs2       in   source register 2 (unused for LH/ANDI)
//   imm       in   signed immediate (byte offset for BEQ, unused for R-type)
//   word      out  encoded instruction
//   range_ok  out  immediate fits the format of op
module instruction_encoder_field_packer
    import instruction_encoder_pkg::*;
(
    input  op_sel_e     op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_ok
);

    always_comb begin
        word     = '0;
        range_ok = 1'b1;
        case (op)
            OP_LH: begin
                word     = {imm[11:0], rs1, F3_LH, rd, OPC_LOAD};
                range_ok = imm12_fits(imm);
            end
            OP_ANDI: begin
                word     = {imm[11:0], rs1, F3_ANDI, rd, OPC_OP_IMM};
                range_ok = imm12_fits(imm);
            end
            OP_SH: begin
                word     = {imm[11:5], rs2, rs1, F3_SH, imm[4:0], OPC_STORE};
                range_ok = imm12_fits(imm);
            end
            OP_BEQ: begin
                word     = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
                range_ok = immb_fits(imm);
            end
            OP_ADD: word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
            OP_SUB: word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
            OP_AND: word = {F7_BASE, rs2, rs1, F3_AND,     rd, OPC_OP};
            OP_OR:  word = {F7_BASE, rs2, rs1, F3_OR,      rd, OPC_OP};
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes instruction requests into RV32I words and writes accepted words
// sequentially into instruction memory (program loader).
//
//   state | meaning
//   IDLE  | waiting for a request; in_ready when not full and not clearing
//   ENC   | latched request is encoded and range-checked
//   WR    | one-cycle write strobe to instruction memory
//   ERR   | one-cycle err pulse, nothing written
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   clear                pointer/count back to start, aborts in-flight request
//   in_valid, in_ready   request handshake
//   in_op, in_rd, in_rs1, in_rs2, in_imm  request fields
//   imem_we, imem_addr, imem_wdata        instruction memory write port
//   err                  request rejected (immediate out of range)
//   full                 DEPTH words written; no further requests accepted
//   count                words written since reset/clear
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [31:0]                in_imm,
    output logic                       imem_we,
    output logic [31:0]                imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       err,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ENC, WR, ERR} state_e;

    state_e        state;
    op_sel_e       op_q;
    logic [4:0]    rd_q;
    logic [4:0]    rs1_q;
    logic [4:0]    rs2_q;
    logic [31:0]   imm_q;
    logic [31:0]   ptr;
    logic [CW-1:0] count_q;
    logic          we_q;
    logic          err_q;
    logic [31:0]   pack_word;
    logic          pack_ok;

    instruction_encoder_field_packer u_packer (
        .op       (op_q),
        .rd       (rd_q),
        .rs1      (rs1_q),
        .rs2      (rs2_q),
        .imm      (imm_q),
        .word     (pack_word),
        .range_ok (pack_ok)
    );

    assign full     = (count_q == DEPTH_C);
    assign count    = count_q;
    assign err      = err_q;
    assign in_ready = (state == IDLE) && !full && !clear && !rst;
    // Memory samples the strobe at the edge that ends WR; masking it with
    // rst/clear makes an abort during WR leave memory untouched.
    assign imem_we  = we_q && !rst && !clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= BASE_ADDR;
            count_q    <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            op_q       <= OP_LH;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
        end else if (clear) begin
            state   <= IDLE;
            ptr     <= BASE_ADDR;
            count_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q  <= op_sel_e'(in_op);
                        rd_q  <= in_rd;
                        rs1_q <= in_rs1;
                        rs2_q <= in_rs2;
                        imm_q <= in_imm;
                        state <= ENC;
                    end
                end
                ENC: begin
                    if (pack_ok) begin
                        imem_addr  <= ptr;
                        imem_wdata <= pack_word;
                        we_q       <= 1'b1;
                        state      <= WR;
                    end else begin
                        err_q <= 1'b1;
                        state <= ERR;
                    end
                end
                WR: begin
                    ptr     <= ptr + 32'd4;
                    count_q <= count_q + CW'(1);
                    state   <= IDLE;
                end
                ERR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          CW    = $clog2(DEPTH + 1);

    localparam int OPC_T [8] = '{3, 35, 19, 99, 51, 51, 51, 51};
    localparam int F3_T  [8] = '{1, 1, 7, 0, 0, 0, 7, 6};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [2:0]    in_op = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [31:0]   in_imm = '0;
    logic          in_ready;
    logic          imem_we;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_wdata;
    logic          err;
    logic          full;
    logic [CW-1:0] count;

    int          n_checks = 0;
    int          n_fail = 0;
    int          strobes = 0;
    int          exp_strobes = 0;
    int          exp_count = 0;
    logic [31:0] exp_ptr = BASE;

    int b_op  [10] = '{2, 2, 1, 1, 3, 3, 0, 1, 3, 3};
    int b_imm [10] = '{-2048, 2047, 2047, -2048, 4094, -4096, -2049, 2048, -4098, 4095};

    instruction_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .err        (err),
        .full       (full),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Memory-side view: a write happens when the strobe is high at a rising edge.
    always @(posedge clk) if (imem_we === 1'b1) strobes <= strobes + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit ref_legal(input int op, input int imm);
        if (op == 0 || op == 1 || op == 2) return (imm >= -2048) && (imm <= 2047);
        if (op == 3) return (imm >= -4096) && (imm <= 4094) && ((imm % 2) == 0);
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_encode(input int op, input int rd, input int rs1,
                                               input int rs2, input int imm);
        logic [31:0] ib, r1, r2, d, opc, f3, w;
        ib  = imm;
        r1  = 32'(rs1);
        r2  = 32'(rs2);
        d   = 32'(rd);
        opc = 32'(OPC_T[op]);
        f3  = 32'(F3_T[op]);
        case (op)
            0, 2: w = ((ib & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | opc;
            1: w = (((ib >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                   | ((ib & 32'h1F) << 7) | opc;
            3: w = (((ib >> 12) & 32'd1) << 31) | (((ib >> 5) & 32'h3F) << 25) | (r2 << 20)
                   | (r1 << 15) | (f3 << 12) | (((ib >> 1) & 32'hF) << 8)
                   | (((ib >> 11) & 32'd1) << 7) | opc;
            default: w = ((op == 5 ? 32'h20 : 32'h0) << 25) | (r2 << 20) | (r1 << 15)
                         | (f3 << 12) | (d << 7) | opc;
        endcase
        return w;
    endfunction

    // Immediate recovery from an encoded word, as an immediate generator would do it.
    function automatic int decode_imm(input int op, input logic [31:0] w);
        int sign_i;
        sign_i = w[31] ? 4096 : 0;
        case (op)
            0, 2: return int'((w >> 20) & 32'hFFF) - sign_i;
            1: return int'(((w >> 25) & 32'h7F) * 32 + ((w >> 7) & 32'h1F)) - sign_i;
            default: return (w[31] ? -4096 : 0) + int'((w >> 7) & 32'd1) * 2048
                            + int'((w >> 25) & 32'h3F) * 32 + int'((w >> 8) & 32'hF) * 2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int op, input int rd, input int rs1, input int rs2, input int imm);
        in_op  = 3'(op);
        in_rd  = 5'(rd);
        in_rs1 = 5'(rs1);
        in_rs2 = 5'(rs2);
        in_imm = imm;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        exp_ptr   = BASE;
        exp_count = 0;
        @(negedge clk);
        check("clr_full", 32'(full), 32'd0);
        check("clr_count", 32'(count), 32'd0);
        check("clr_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic xact(input string tag, input int op, input int rd, input int rs1,
                        input int rs2, input int imm, input logic [31:0] exp_word,
                        input bit exp_ok);
        int w;
        w = 0;
        @(negedge clk);
        drive(op, rd, rs1, rs2, imm);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_enc_we"}, 32'(imem_we), 32'd0);
        check({tag, "_enc_ready"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        check({tag, "_we"}, 32'(imem_we), 32'(exp_ok));
        check({tag, "_err"}, 32'(err), 32'(!exp_ok));
        if (exp_ok) begin
            check({tag, "_addr"}, imem_addr, exp_ptr);
            check({tag, "_wdata"}, imem_wdata, exp_word);
            if (op < 4) check({tag, "_roundtrip"}, 32'(decode_imm(op, imem_wdata)), 32'(imm));
            exp_ptr = exp_ptr + 32'd4;
            exp_count++;
            exp_strobes++;
        end
        @(negedge clk);
        check({tag, "_post_we"}, 32'(imem_we), 32'd0);
        check({tag, "_post_err"}, 32'(err), 32'd0);
        check({tag, "_count"}, 32'(count), 32'(exp_count));
        check({tag, "_strobes"}, 32'(strobes), 32'(exp_strobes));
        check({tag, "_full"}, 32'(full), 32'(exp_count == DEPTH));
    endtask

    initial begin
        int op, rd, rs1, rs2, imm;

        // Reset values while rst is still asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr", imem_addr, BASE);
        check("rst_wdata", imem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);

        // Directed encodings; addresses step by 4 from BASE.
        xact("lh",   0, 10, 5, 0,  -20, 32'hFEC29503, 1'b1);
        xact("sh",   1, 0,  5, 10, 40,  32'h02A29423, 1'b1);
        xact("andi", 2, 10, 5, 0,  255, 32'h0FF2F513, 1'b1);
        xact("beq",  3, 0,  1, 2,  -16, 32'hFE2088E3, 1'b1);

        // Memory full: a held request must not be accepted.
        @(negedge clk);
        check("full_flag", 32'(full), 32'd1);
        check("full_ready", 32'(in_ready), 32'd0);
        drive(2, 1, 2, 0, 1);
        in_valid = 1'b1;
        repeat (10) @(negedge clk);
        check("full_nowrite", 32'(strobes), 32'(exp_strobes));
        check("full_count", 32'(count), 32'(DEPTH));
        check("full_ready_held", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        do_clear();
        xact("add", 4, 3, 1, 2, 0, 32'h002081B3, 1'b1);

        // Out-of-range immediates.
        xact("andi_2048", 2, 1, 2, 0, 2048, 32'd0, 1'b0);
        xact("beq_odd",   3, 0, 1, 2, 3,    32'd0, 1'b0);
        xact("beq_4096",  3, 0, 1, 2, 4096, 32'd0, 1'b0);

        // Range boundaries.
        for (int i = 0; i < 10; i++) begin
            if (exp_count == DEPTH) do_clear();
            xact("bound", b_op[i], 7, 8, 9, b_imm[i],
                 ref_encode(b_op[i], 7, 8, 9, b_imm[i]), ref_legal(b_op[i], b_imm[i]));
        end

        // Clear in the same cycle as in_valid: request refused.
        @(negedge clk);
        drive(4, 1, 2, 3, 0);
        in_valid = 1'b1;
        clear    = 1'b1;
        #1 check("clrv_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 begin
            clear    = 1'b0;
            in_valid = 1'b0;
        end
        exp_ptr   = BASE;
        exp_count = 0;
        @(negedge clk);
        check("clrv_idle", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        check("clrv_nowrite", 32'(strobes), 32'(exp_strobes));

        // Clear during ENC aborts the write and rewinds the pointer.
        xact("pre_clr", 6, 4, 5, 6, 0, ref_encode(6, 4, 5, 6, 0), 1'b1);
        @(negedge clk);
        drive(2, 3, 4, 0, 5);
        in_valid = 1'b1;
        @(posedge clk);
        #1 begin
            in_valid = 1'b0;
            clear    = 1'b1;
        end
        @(posedge clk);
        #1 clear = 1'b0;
        exp_ptr   = BASE;
        exp_count = 0;
        @(negedge clk);
        check("clre_we", 32'(imem_we), 32'd0);
        check("clre_ready", 32'(in_ready), 32'd1);
        check("clre_count", 32'(count), 32'd0);
        @(negedge clk);
        check("clre_nowrite", 32'(strobes), 32'(exp_strobes));
        check("clre_err", 32'(err), 32'd0);
        xact("post_clr", 7, 9, 10, 11, 0, ref_encode(7, 9, 10, 11, 0), 1'b1);

        // Reset during WR: no write reaches memory, outputs back to reset values.
        xact("pre_rst", 5, 12, 13, 14, 0, ref_encode(5, 12, 13, 14, 0), 1'b1);
        @(negedge clk);
        drive(1, 0, 2, 3, 8);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rstw_we", 32'(imem_we), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_ptr   = BASE;
        exp_count = 0;
        @(negedge clk);
        check("rstw_ready", 32'(in_ready), 32'd1);
        check("rstw_count", 32'(count), 32'd0);
        check("rstw_addr", imem_addr, BASE);
        check("rstw_wdata", imem_wdata, 32'd0);
        check("rstw_nowrite", 32'(strobes), 32'(exp_strobes));
        xact("post_rst", 4, 1, 1, 1, 0, ref_encode(4, 1, 1, 1, 0), 1'b1);

        // Randomized requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            op  = int'($urandom_range(0, 7));
            rd  = int'($urandom_range(0, 31));
            rs1 = int'($urandom_range(0, 31));
            rs2 = int'($urandom_range(0, 31));
            if (op == 3)
                imm = ($urandom_range(0, 3) != 0) ? (int'($urandom_range(0, 4095)) - 2048) * 2
                                                  : int'($urandom_range(0, 20000)) - 10000;
            else
                imm = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 4095)) - 2048
                                                  : int'($urandom_range(0, 20000)) - 10000;
            if (exp_count == DEPTH) do_clear();
            xact("rnd", op, rd, rs1, rs2, imm, ref_encode(op, rd, rs1, rs2, imm),
                 ref_legal(op, imm));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
